// File: rtl/jump_btn_conditioner.sv
// Jump button conditioner: sync, debounce, one-shot strobe, press counter.
// Optional auto-repeat while held: define JUMP_AUTOREPEAT_EN.
module jump_btn_conditioner #(
  parameter int N_DC  = 25,
  parameter int RPT_W = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       jump_pulse,
  output logic       db_level,
  output logic [7:0] press_cnt
);

  typedef enum logic [2:0] {
    INI,
    WQ,
    PULSE,
    HELD,
    WFR
  } state_e;

  localparam logic [N_DC-1:0] DC_MAX = {N_DC{1'b1}};

  if (N_DC < 1 || RPT_W < 1) begin : g_param_chk
    $error("jump_btn_conditioner: widths must be positive");
  end

  logic            sync1_q;
  logic            sync2_q;
  logic            btn_s;
  state_e          state_q;
  state_e          state_d;
  logic [N_DC-1:0] cnt_q;
  logic [N_DC-1:0] cnt_d;
  logic            pulse_q;
  logic            level_q;
  logic [7:0]      press_q;

`ifdef JUMP_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_MAX = {RPT_W{1'b1}};
  logic [RPT_W-1:0] rpt_q;
  logic [RPT_W-1:0] rpt_d;
`endif

  assign btn_s      = sync2_q;
  assign jump_pulse = pulse_q;
  assign db_level   = level_q;
  assign press_cnt  = press_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Next state and counters; counters clear whenever the state changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef JUMP_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    unique case (state_q)
      INI: begin
        if (btn_s) state_d = WQ;
      end
      WQ: begin
        if (!btn_s)              state_d = INI;
        else if (cnt_q == DC_MAX) state_d = PULSE;
        else                     cnt_d = cnt_q + 1'b1;
      end
      PULSE: begin
        state_d = HELD;
      end
      HELD: begin
        if (!btn_s) state_d = WFR;
`ifdef JUMP_AUTOREPEAT_EN
        else if (rpt_q == RPT_MAX) state_d = PULSE;
        else rpt_d = rpt_q + 1'b1;
`endif
      end
      WFR: begin
        if (btn_s)               state_d = HELD;
        else if (cnt_q == DC_MAX) state_d = INI;
        else                     cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = INI;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef JUMP_AUTOREPEAT_EN
      rpt_d = '0;
`endif
    end
  end

  // State, counters and Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INI;
      cnt_q   <= '0;
`ifdef JUMP_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef JUMP_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
      pulse_q <= (state_d == PULSE);
      level_q <= (state_d == PULSE) ||
                 (state_d == HELD)  ||
                 (state_d == WFR);
      if (state_d == PULSE) press_q <= press_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_jump_btn_conditioner.sv
// Testbench for jump_btn_conditioner with N_DC=4, RPT_W=5.
// Strobe expectations are queued by the stimulus and checked by a monitor.
module tb_jump_btn_conditioner;

  localparam int NDC  = 4;
  localparam int RPTW = 5;
  localparam int LAT  = (1 << NDC) + 2;
  localparam int RPER = (1 << RPTW) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       jump_pulse;
  logic       db_level;
  logic [7:0] press_cnt;

  typedef struct {
    int cyc;
    int pcnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   model_cnt = 0;

  jump_btn_conditioner #(
    .N_DC (NDC),
    .RPT_W(RPTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .jump_pulse(jump_pulse),
    .db_level  (db_level),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic expect_strobe(input int c);
    exp_t e;
    model_cnt = (model_cnt + 1) % 256;
    e.cyc  = c;
    e.pcnt = model_cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (jump_pulse !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe cyc=%0d press_cnt=%0d",
                 cyc, press_cnt);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || press_cnt !== e.pcnt[7:0]) begin
          n_err++;
          $display("FAIL strobe got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d",
                   cyc, press_cnt, e.cyc, e.pcnt);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      btn = (i % 3 == 0);
      n_cmp++;
      if ({jump_pulse, db_level, press_cnt} !== 10'b0) begin
        n_err++;
        $display("FAIL reset_hold got p=%b l=%b c=%0d want 0/0/0",
                 jump_pulse, db_level, press_cnt);
      end
    end
    btn = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (db_level !== 1'b0 || press_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_idle got l=%b c=%0d want 0/0",
               db_level, press_cnt);
    end
  endtask

  task automatic test_clean_press();
    int  k;
    logic want;
    @(negedge clk);
    btn = 1'b1;
    k = cyc + 1;
    expect_strobe(k + LAT);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 39) btn = 1'b0;
      if (cyc == k + LAT - 1 || cyc == k + LAT ||
          cyc == k + 40 + LAT - 1 || cyc == k + 40 + LAT) begin
        want = (cyc >= k + LAT) && (cyc < k + 40 + LAT);
        n_cmp++;
        if (db_level !== want) begin
          n_err++;
          $display("FAIL clean_level cyc=%0d got %b want %b",
                   cyc - k, db_level, want);
        end
      end
    end
    n_cmp++;
    if (press_cnt !== model_cnt[7:0] || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clean_cnt got %0d want %0d pending=%0d",
               press_cnt, model_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int j;
    @(negedge clk);
    btn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      j = i + 1;
      btn = (j < 10) || (j >= 11 && j < 21);
      n_cmp++;
      if (db_level !== 1'b0) begin
        n_err++;
        $display("FAIL bounce_level i=%0d got %b want 0", i, db_level);
      end
    end
    n_cmp++;
    if (press_cnt !== model_cnt[7:0]) begin
      n_err++;
      $display("FAIL bounce_cnt got %0d want %0d", press_cnt, model_cnt);
    end
  endtask

  task automatic test_release_glitch();
    int  k;
    int  j;
    logic want;
    @(negedge clk);
    btn = 1'b1;
    k = cyc + 1;
    expect_strobe(k + LAT);
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      j = i + 1;
      btn = (j < 25) || (j >= 30 && j < 50);
      want = (cyc >= k + LAT) && (cyc < k + 50 + LAT);
      n_cmp++;
      if (db_level !== want) begin
        n_err++;
        $display("FAIL glitch_level cyc=%0d got %b want %b",
                 cyc - k, db_level, want);
      end
    end
    n_cmp++;
    if (press_cnt !== model_cnt[7:0] || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_cnt got %0d want %0d pending=%0d",
               press_cnt, model_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_autorepeat();
    int k;
    @(negedge clk);
    btn = 1'b1;
    k = cyc + 1;
    expect_strobe(k + LAT);
`ifdef JUMP_AUTOREPEAT_EN
    expect_strobe(k + LAT + RPER);
    expect_strobe(k + LAT + 2 * RPER);
`endif
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i == 99) btn = 1'b0;
      if (cyc == k + 100 + LAT - 1 || cyc == k + 100 + LAT) begin
        n_cmp++;
        if (db_level !== (cyc == k + 100 + LAT - 1)) begin
          n_err++;
          $display("FAIL repeat_level cyc=%0d got %b", cyc - k, db_level);
        end
      end
    end
    n_cmp++;
    if (press_cnt !== model_cnt[7:0] || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL repeat_cnt got %0d want %0d pending=%0d",
               press_cnt, model_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_wq();
    int k;
    @(negedge clk);
    btn = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (i == 54) btn = 1'b0;
      if (cyc == k + 10) begin
        rst = 1'b0;
        model_cnt = 0;
      end
      if (cyc == k + 12) begin
        n_cmp++;
        if ({jump_pulse, db_level, press_cnt} !== 10'b0) begin
          n_err++;
          $display("FAIL midwq_reset got p=%b l=%b c=%0d want 0/0/0",
                   jump_pulse, db_level, press_cnt);
        end
        rst = 1'b1;
        expect_strobe(k + 13 + LAT);
      end
    end
    n_cmp++;
    if (press_cnt !== model_cnt[7:0] || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL midwq_cnt got %0d want %0d pending=%0d",
               press_cnt, model_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    int k;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 256; p++) begin
      @(negedge clk);
      btn = 1'b1;
      k = cyc + 1;
      expect_strobe(k + LAT);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 19) btn = 1'b0;
      end
      if (p == 254) begin
        n_cmp++;
        if (press_cnt !== 8'd255) begin
          n_err++;
          $display("FAIL wrap_255 got %0d want 255", press_cnt);
        end
      end
    end
    n_cmp++;
    if (press_cnt !== 8'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_zero got %0d want 0 pending=%0d",
               press_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_autorepeat();
    test_reset_mid_wq();
    test_wrap();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
